regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port (6-bit writenum with bit 5 = write enable, 32-bit writedata) between two writeback sources: the ALU result path and the memory-load result path. Each source has a small FIFO. Source heads are granted round-robin, and one write is driven per clock. The block also exports a pending-write mask, which issue logic uses to stall reads of registers whose writes are still in flight.

---
 rtl/regfile_wb_arbiter_pkg.sv | 24 ++
 rtl/regfile_wb_arbiter_fifo.sv | 111 +++++++++++
 rtl/regfile_wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// the write-enable bit position, the round-robin state encoding and the
// writeback entry layout.
package regfile_wb_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 5;

    // Position of the write enable inside writenum (just above the index).
    localparam int WE_BIT = 5;

    // Remembers which source won the most recent grant.
    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } arb_state_e;

    // One buffered writeback: destination register and its data.
    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] num;
        logic [DATA_W_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Per-source writeback FIFO. Presents its head entry, an occupancy count, a
// ready flag derived only from the registered count, and a per-entry valid
// and destination vector so the top can build the pending-write mask.
module wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [ADDR_W-1:0]        push_num_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic                     ready_o,
    output logic [CNT_W-1:0]         count_o,
    output logic                     head_valid_o,
    output logic [ADDR_W-1:0]        head_num_o,
    output logic [DATA_W-1:0]        head_data_o,
    output logic [DEPTH-1:0]         entry_valid_o,
    output logic [DEPTH*ADDR_W-1:0]  entry_num_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] num_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    logic do_push;
    logic do_pop;

    // Pointers wrap modulo DEPTH, which need not fill the pointer width.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign ready_o      = (count_q < FULL_CNT);
    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_num_o   = num_q[rd_ptr_q];
    assign head_data_o  = data_q[rd_ptr_q];

    assign do_push = push_i & ready_o;
    assign do_pop  = pop_i & head_valid_o;

    // Next-state for pointers, occupancy and per-entry valid flags.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (do_pop) begin
            rd_ptr_d          = next_ptr(rd_ptr_q);
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (do_push) begin
            wr_ptr_d          = next_ptr(wr_ptr_q);
            valid_d[wr_ptr_q] = 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state: emptied by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage, written only on an accepted push.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset; stale contents are never observed because valid_q/count_q gate every use.
        if (do_push) begin
            num_q[wr_ptr_q]  <= push_num_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Flatten per-entry destinations for the pending-mask builder.
    always_comb begin
        entry_num_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_num_o[i*ADDR_W +: ADDR_W] = num_q[i];
        end
    end

    assign entry_valid_o = valid_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter. Two sources (ALU results and load data)
// each feed a small FIFO; the heads are granted round-robin and one write per
// clock is registered onto the register file's single write port. A pending
// mask flags every register whose write is buffered or currently on the port.
// Optional build macro WB_ZERO_GUARD_EN: writes to register 0 are accepted
// by the handshake but dropped, and pending_o[0] is forced low.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   alu_valid_i,
    output logic                   alu_ready_o,
    input  logic [ADDR_W-1:0]      alu_num_i,
    input  logic [DATA_W-1:0]      alu_data_i,
    input  logic                   mem_valid_i,
    output logic                   mem_ready_o,
    input  logic [ADDR_W-1:0]      mem_num_i,
    input  logic [DATA_W-1:0]      mem_data_i,
    output logic [ADDR_W:0]        writenum_o,
    output logic [DATA_W-1:0]      writedata_o,
    output logic [(1<<ADDR_W)-1:0] pending_o,
    output logic                   idle_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic alu_keep, mem_keep;
    logic alu_push, mem_push;
    logic grant_alu, grant_mem;

    logic [CNT_W-1:0]        alu_count, mem_count;
    logic                    alu_head_valid, mem_head_valid;
    logic [ADDR_W-1:0]       alu_head_num, mem_head_num;
    logic [DATA_W-1:0]       alu_head_data, mem_head_data;
    logic [DEPTH-1:0]        alu_entry_valid, mem_entry_valid;
    logic [DEPTH*ADDR_W-1:0] alu_entry_num, mem_entry_num;

    arb_state_e state_q, state_d;

    logic [ADDR_W:0]   writenum_q, writenum_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;

`ifdef WB_ZERO_GUARD_EN
    // Register 0 writes complete the handshake but are never buffered.
    assign alu_keep = (alu_num_i != '0);
    assign mem_keep = (mem_num_i != '0);
`else
    assign alu_keep = 1'b1;
    assign mem_keep = 1'b1;
`endif

    assign alu_push = alu_valid_i & alu_ready_o & alu_keep;
    assign mem_push = mem_valid_i & mem_ready_o & mem_keep;

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_alu_fifo (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .push_i        (alu_push),
        .push_num_i    (alu_num_i),
        .push_data_i   (alu_data_i),
        .pop_i         (grant_alu),
        .ready_o       (alu_ready_o),
        .count_o       (alu_count),
        .head_valid_o  (alu_head_valid),
        .head_num_o    (alu_head_num),
        .head_data_o   (alu_head_data),
        .entry_valid_o (alu_entry_valid),
        .entry_num_o   (alu_entry_num)
    );

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_mem_fifo (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .push_i        (mem_push),
        .push_num_i    (mem_num_i),
        .push_data_i   (mem_data_i),
        .pop_i         (grant_mem),
        .ready_o       (mem_ready_o),
        .count_o       (mem_count),
        .head_valid_o  (mem_head_valid),
        .head_num_o    (mem_head_num),
        .head_data_o   (mem_head_data),
        .entry_valid_o (mem_entry_valid),
        .entry_num_o   (mem_entry_num)
    );

    // Round-robin state register; reset prefers the ALU first.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= LAST_MEM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state records the granted source; unchanged when nothing is granted.
    always_comb begin
        state_d = state_q;
        case ({alu_head_valid, mem_head_valid})
            2'b10:   state_d = LAST_ALU;
            2'b01:   state_d = LAST_MEM;
            2'b11:   state_d = (state_q == LAST_MEM) ? LAST_ALU : LAST_MEM;
            default: state_d = state_q;
        endcase
    end

    // Grant decode: a lone head wins; under contention the source not last served wins.
    always_comb begin
        grant_alu = alu_head_valid & (~mem_head_valid | (state_q == LAST_MEM));
        grant_mem = mem_head_valid & (~alu_head_valid | (state_q == LAST_ALU));
    end

    // Write-port next value: one-cycle write on a grant, data held otherwise.
    always_comb begin
        writenum_d  = '0;
        writedata_d = writedata_q;
        if (grant_alu) begin
            writenum_d  = {1'b1, alu_head_num};
            writedata_d = alu_head_data;
        end else if (grant_mem) begin
            writenum_d  = {1'b1, mem_head_num};
            writedata_d = mem_head_data;
        end
    end

    // Write-port register, updated on posedge so it is stable by the negedge read.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            writenum_q  <= '0;
            writedata_q <= '0;
        end else begin
            writenum_q  <= writenum_d;
            writedata_q <= writedata_d;
        end
    end

    assign writenum_o  = writenum_q;
    assign writedata_o = writedata_q;

    // Pending mask: every buffered destination plus the write on the port.
    always_comb begin
        pending_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_entry_valid[i]) pending_o[alu_entry_num[i*ADDR_W +: ADDR_W]] = 1'b1;
            if (mem_entry_valid[i]) pending_o[mem_entry_num[i*ADDR_W +: ADDR_W]] = 1'b1;
        end
        if (writenum_q[ADDR_W]) pending_o[writenum_q[ADDR_W-1:0]] = 1'b1;
`ifdef WB_ZERO_GUARD_EN
        pending_o[0] = 1'b0;
`endif
    end

    assign idle_o = (alu_count == '0) && (mem_count == '0) && !writenum_q[ADDR_W];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus pushes the
// hand-ordered expected register-file writes; a negedge monitor pops and
// compares every asserted write. Honours WB_ZERO_GUARD_EN when defined.
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i = 1'b0;
    logic                   alu_valid_i = 1'b0;
    logic                   alu_ready_o;
    logic [ADDR_W-1:0]      alu_num_i = '0;
    logic [DATA_W-1:0]      alu_data_i = '0;
    logic                   mem_valid_i = 1'b0;
    logic                   mem_ready_o;
    logic [ADDR_W-1:0]      mem_num_i = '0;
    logic [DATA_W-1:0]      mem_data_i = '0;
    logic [ADDR_W:0]        writenum_o;
    logic [DATA_W-1:0]      writedata_o;
    logic [(1<<ADDR_W)-1:0] pending_o;
    logic                   idle_o;

    int checks   = 0;
    int failures = 0;

    wb_entry_t exp_q[$];
    wb_entry_t mon_e;

    // Backpressure table: expected ready before each of six edges with both valids held.
    bit exp_ar [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    bit exp_mr [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .alu_valid_i (alu_valid_i),
        .alu_ready_o (alu_ready_o),
        .alu_num_i   (alu_num_i),
        .alu_data_i  (alu_data_i),
        .mem_valid_i (mem_valid_i),
        .mem_ready_o (mem_ready_o),
        .mem_num_i   (mem_num_i),
        .mem_data_i  (mem_data_i),
        .writenum_o  (writenum_o),
        .writedata_o (writedata_o),
        .pending_o   (pending_o),
        .idle_o      (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input int num, input logic [31:0] data);
        exp_q.push_back(wb_entry_t'{num: 5'(num), data: data});
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        alu_valid_i = 1'b0;
        mem_valid_i = 1'b0;
        rst_n_i     = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
    endtask

    // Monitor: every write the register file would sample must match the scoreboard head.
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1 && writenum_o[WE_BIT] === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got writenum 0x%0h data 0x%0h expected no write",
                         writenum_o, writedata_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_num", 64'(writenum_o), 64'({1'b1, mon_e.num}));
                check("wb_data", 64'(writedata_o), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got no finish expected finish before 20000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ai;
        int mi;

        // ---- 1: reset state, single ALU write with one-cycle latency/width
        do_reset();
        check("rst_writenum", 64'(writenum_o), 64'h0);
        check("rst_writedata", 64'(writedata_o), 64'h0);
        check("rst_pending", 64'(pending_o), 64'h0);
        check("rst_idle", 64'(idle_o), 64'h1);
        check("rst_alu_ready", 64'(alu_ready_o), 64'h1);
        check("rst_mem_ready", 64'(mem_ready_o), 64'h1);

        alu_valid_i = 1'b1; alu_num_i = 5'd3; alu_data_i = 32'h11;
        expect_wb(3, 32'h11);
        step();                                   // edge 1: transfer
        alu_valid_i = 1'b0;
        check("t1_pend3_e1", 64'(pending_o[3]), 64'h1);
        check("t1_not_early", 64'(writenum_o), 64'h0);
        check("t1_busy", 64'(idle_o), 64'h0);
        step();                                   // edge 2: write on port
        check("t1_pend3_e2", 64'(pending_o[3]), 64'h1);
        step();                                   // edge 3: write retired
        check("t1_one_cycle", 64'(writenum_o), 64'h0);
        check("t1_data_hold", 64'(writedata_o), 64'h11);
        check("t1_pend_clear", 64'(pending_o), 64'h0);
        check("t1_idle", 64'(idle_o), 64'h1);

        // ---- 2: simultaneous pushes, round-robin order A1 M2 A5 M6 A7 M8
        do_reset();
        alu_valid_i = 1'b1; alu_num_i = 5'd1; alu_data_i = 32'hA;
        mem_valid_i = 1'b1; mem_num_i = 5'd2; mem_data_i = 32'hB;
        expect_wb(1, 32'hA); expect_wb(2, 32'hB);
        step();                                   // edge 1
        check("t2_pending", 64'(pending_o), 64'h6);
        alu_num_i = 5'd5; alu_data_i = 32'h15;
        mem_num_i = 5'd6; mem_data_i = 32'h26;
        expect_wb(5, 32'h15); expect_wb(6, 32'h26);
        step();                                   // edge 2
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        check("t2_mem_full", 64'(mem_ready_o), 64'h0);
        check("t2_alu_ready", 64'(alu_ready_o), 64'h1);
        step();                                   // edge 3
        alu_valid_i = 1'b1; alu_num_i = 5'd7; alu_data_i = 32'h37;
        mem_valid_i = 1'b1; mem_num_i = 5'd8; mem_data_i = 32'h48;
        expect_wb(7, 32'h37); expect_wb(8, 32'h48);
        step();                                   // edge 4
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        repeat (4) step();

        // ---- 3: both sources held valid, FIFO fills and back-pressures
        do_reset();
        for (int i = 0; i < 4; i++) begin
            expect_wb(10 + i, 32'hA0 + 32'(i));
            expect_wb(20 + i, 32'hB0 + 32'(i));
        end
        ai = 0;
        mi = 0;
        for (int e = 0; e < 6; e++) begin
            alu_valid_i = 1'b1; alu_num_i = 5'(10 + ai); alu_data_i = 32'hA0 + 32'(ai);
            mem_valid_i = 1'b1; mem_num_i = 5'(20 + mi); mem_data_i = 32'hB0 + 32'(mi);
            check($sformatf("t3_alu_ready_e%0d", e + 1), 64'(alu_ready_o), 64'(exp_ar[e]));
            check($sformatf("t3_mem_ready_e%0d", e + 1), 64'(mem_ready_o), 64'(exp_mr[e]));
            step();
            if (exp_ar[e]) ai++;
            if (exp_mr[e]) mi++;
        end
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        repeat (4) step();

        // ---- 4: asynchronous reset with three entries buffered
        do_reset();
        alu_valid_i = 1'b1; alu_num_i = 5'd9;  alu_data_i = 32'h91;
        mem_valid_i = 1'b1; mem_num_i = 5'd12; mem_data_i = 32'hC1;
        step();                                   // edge 1
        alu_num_i = 5'd11; alu_data_i = 32'hB1;
        mem_num_i = 5'd13; mem_data_i = 32'hD1;
        step();                                   // edge 2: r9 on port, 3 buffered
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        check("t4_pending_full", 64'(pending_o), 64'h3A00);
        check("t4_out_before_rst", 64'(writenum_o), 64'h29);
        rst_n_i = 1'b0;
        #1;
        check("t4_rst_writenum", 64'(writenum_o), 64'h0);
        check("t4_rst_writedata", 64'(writedata_o), 64'h0);
        check("t4_rst_pending", 64'(pending_o), 64'h0);
        check("t4_rst_idle", 64'(idle_o), 64'h1);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        repeat (5) step();
        check("t4_after_pending", 64'(pending_o), 64'h0);
        check("t4_after_idle", 64'(idle_o), 64'h1);

        // ---- 5: write to register 0 followed by r4
        do_reset();
        mem_valid_i = 1'b1; mem_num_i = 5'd0; mem_data_i = 32'hFF;
`ifndef WB_ZERO_GUARD_EN
        expect_wb(0, 32'hFF);
`endif
        step();                                   // edge 1
`ifdef WB_ZERO_GUARD_EN
        check("t5_pend0_e1", 64'(pending_o[0]), 64'h0);
`else
        check("t5_pend0_e1", 64'(pending_o[0]), 64'h1);
`endif
        mem_num_i = 5'd4; mem_data_i = 32'h5;
        expect_wb(4, 32'h5);
        step();                                   // edge 2
        mem_valid_i = 1'b0;
`ifdef WB_ZERO_GUARD_EN
        check("t5_pend0_e2", 64'(pending_o[0]), 64'h0);
`else
        check("t5_pend0_e2", 64'(pending_o[0]), 64'h1);
`endif
        check("t5_pend4_e2", 64'(pending_o[4]), 64'h1);
        repeat (3) step();

        // ---- drain: every expected write must have been observed
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("drain_empty", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
